// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
//
// Purpose: bundles the requester-side and master-port-side signals of
// bus_arbiter so the arbiter and its environment connect through a single
// port.
//
// Parameters:
//   REQ_COUNT  number of requesters (2..8)
//   PTR_W      width of the grant index, $clog2(REQ_COUNT) with a minimum of 1
//
// Signals:
//   req_valid/req_write/req_addr/req_wdata  per-requester transfer request
//   req_done/req_rdata/req_resp             completion pulse, read data, response
//   m_start/m_write/m_address/m_write_data  AHB-Lite master-port request
//   m_read_data/m_response/m_ready          AHB-Lite master-port return path
//   grant/busy                              diagnostic owner index and activity
//
// Modports:
//   master  the arbiter side (drives completions and the master port)
//   slave   the environment side (requesters plus the bus_control port)
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
   parameter int REQ_COUNT = 2,
   parameter int PTR_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
);
   logic [REQ_COUNT-1:0]    req_valid;
   logic [REQ_COUNT-1:0]    req_write;
   logic [32*REQ_COUNT-1:0] req_addr;
   logic [32*REQ_COUNT-1:0] req_wdata;
   logic [REQ_COUNT-1:0]    req_done;
   logic [31:0]             req_rdata;
   logic                    req_resp;
   logic                    m_start;
   logic                    m_write;
   logic [31:0]             m_address;
   logic [31:0]             m_write_data;
   logic [31:0]             m_read_data;
   logic                    m_response;
   logic                    m_ready;
   logic [PTR_W-1:0]        grant;
   logic                    busy;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  m_read_data, m_response, m_ready,
      output req_done, req_rdata, req_resp,
      output m_start, m_write, m_address, m_write_data,
      output grant, busy
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output m_read_data, m_response, m_ready,
      input  req_done, req_rdata, req_resp,
      input  m_start, m_write, m_address, m_write_data,
      input  grant, busy
   );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Purpose: shares the single AHB-Lite master port of bus_control between
// REQ_COUNT core requesters (e.g. instruction fetch at index 0, load/store at
// index 1). Round-robin arbitration, one outstanding transfer at a time; the
// owner keeps the grant from address phase until its data phase completes and
// then receives read data, response and a one-cycle done pulse.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   bus_arbiter_if.master: requester inputs, req_done/req_rdata/req_resp
//         completion outputs, m_* master-port signals, grant and busy
//
// All outputs are registered. States: IDLE (arbitrate), ISSUE (address phase,
// m_start high), DATA (wait for data-phase HREADY).
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int REQ_COUNT = 2,
   parameter int PTR_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
   input logic           clk,
   input logic           rst,
   bus_arbiter_if.master bus
);
   localparam int SW = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   m_start_q, m_start_d;
   logic                   m_write_q, m_write_d;
   logic [31:0]            m_addr_q, m_addr_d;
   logic [31:0]            m_wdata_q, m_wdata_d;
   logic [REQ_COUNT-1:0]   done_q, done_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   resp_q, resp_d;
   logic [PTR_W-1:0]       grant_q, grant_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic                   busy_q, busy_d;

   // Round-robin search: rotate the request vector so that bit 0 corresponds
   // to the pointer, take the first set bit, then map back to an absolute
   // index modulo REQ_COUNT (works for non-power-of-two counts).
   logic [2*REQ_COUNT-1:0] dbl_req;
   logic [REQ_COUNT-1:0]   rot_req;
   logic                   win_found;
   logic [SW-1:0]          win_sum;
   logic [PTR_W-1:0]       win_idx;

   always_comb begin
      dbl_req   = {bus.req_valid, bus.req_valid} >> ptr_q;
      rot_req   = dbl_req[REQ_COUNT-1:0];
      win_found = 1'b0;
      win_sum   = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         if (!win_found && rot_req[k]) begin
            win_found = 1'b1;
            win_sum   = {1'b0, ptr_q} + SW'(k);
         end
      end
      if (win_sum >= SW'(REQ_COUNT)) begin
         win_sum = win_sum - SW'(REQ_COUNT);
      end
      win_idx = win_sum[PTR_W-1:0];
   end

   // Request attributes of the winner, latched into m_* at grant.
   logic        sel_write;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         if (win_idx == PTR_W'(k)) begin
            sel_write = bus.req_write[k];
            sel_addr  = bus.req_addr[32*k +: 32];
            sel_wdata = bus.req_wdata[32*k +: 32];
         end
      end
   end

   // Pointer moves one past the owner that just completed, wrapping to 0.
   logic [PTR_W-1:0] ptr_nxt;
   assign ptr_nxt = (grant_q == PTR_W'(REQ_COUNT - 1)) ? '0 : grant_q + PTR_W'(1);

   always_comb begin
      state_d   = state_q;
      m_start_d = m_start_q;
      m_write_d = m_write_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      done_d    = '0;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      busy_d    = busy_q;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d   = win_idx;
               m_write_d = sel_write;
               m_addr_d  = sel_addr;
               m_wdata_d = sel_wdata;
               m_start_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            // Address phase is accepted when the slave reports HREADY.
            if (bus.m_ready) begin
               m_start_d = 1'b0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bus.m_ready) begin
               rdata_d = bus.m_read_data;
               resp_d  = bus.m_response;
               done_d  = REQ_COUNT'(1) << grant_q;
               ptr_d   = ptr_nxt;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         m_start_q <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         resp_q    <= 1'b0;
         grant_q   <= '0;
         ptr_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_start_q <= m_start_d;
         m_write_q <= m_write_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.m_start      = m_start_q;
   assign bus.m_write      = m_write_q;
   assign bus.m_address    = m_addr_q;
   assign bus.m_write_data = m_wdata_q;
   assign bus.req_done     = done_q;
   assign bus.req_rdata    = rdata_q;
   assign bus.req_resp     = resp_q;
   assign bus.grant        = grant_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Bench for bus_arbiter with three requesters. A transaction-level model walks
// the round-robin ring to predict the grant order of each batch of requests and
// pushes the expected transfers into queues; a bus-slave process plays
// bus_control with random or scripted HREADY and returns read data/response;
// a monitor pops and compares whenever the DUT starts a transfer or pulses
// req_done.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
   localparam int N  = 3;
   localparam int PW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_arbiter_if #(.REQ_COUNT(N)) bif ();

   bus_arbiter #(.REQ_COUNT(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      int          idx;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   xfer_t       bus_q[$];
   xfer_t       done_q[$];
   logic [32:0] resp_q[$];      // {response, read data} per data-phase completion
   bit          rdy_script[$];
   logic [32:0] data_script[$];
   int          ready_pct = 100;

   bit          a_wr[N];
   logic [31:0] a_addr[N];
   logic [31:0] a_wdata[N];

   int tests = 0;
   int fails = 0;
   int model_ptr = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: walk the ring from the pointer; every requester in the
   // set is served in ring order, and the pointer ends one past the last owner.
   function automatic int model_expect(input logic [N-1:0] subset, input int hold_n);
      int    cnt;
      int    want;
      xfer_t x;
      cnt  = 0;
      want = (hold_n > 0) ? hold_n : $countones(subset);
      while (cnt < want) begin
         if (subset[PW'(model_ptr)]) begin
            x.idx   = model_ptr;
            x.wr    = a_wr[model_ptr];
            x.addr  = a_addr[model_ptr];
            x.wdata = a_wdata[model_ptr];
            bus_q.push_back(x);
            done_q.push_back(x);
            cnt++;
         end
         model_ptr = (model_ptr + 1) % N;
      end
      return want;
   endfunction

   task automatic apply_attrs();
      for (int i = 0; i < N; i++) begin
         bif.req_write[i]          = a_wr[i];
         bif.req_addr[i*32 +: 32]  = a_addr[i];
         bif.req_wdata[i*32 +: 32] = a_wdata[i];
      end
   endtask

   task automatic flush_model();
      bus_q.delete();
      done_q.delete();
      resp_q.delete();
      rdy_script.delete();
      data_script.delete();
      model_ptr = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bif.req_valid = '0;
      flush_model();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Raise a set of requests together and service them to completion.
   // hold_n > 0: requests are held (renewed) for hold_n transfers in total.
   // rnd_drop: the owner may drop req_valid and scramble its address/data
   // right after grant.
   task automatic run_batch(input logic [N-1:0] subset, input int hold_n, input bit rnd_drop);
      int total;
      int seen;
      int budget;
      int g;
      bit prev;
      apply_attrs();
      total = model_expect(subset, hold_n);
      @(negedge clk);
      bif.req_valid = subset;
      seen   = 0;
      budget = 0;
      prev   = 1'b0;
      while (seen < total && budget < 400) begin
         @(negedge clk);
         budget++;
         if (bif.req_done != '0) begin
            seen++;
            if (hold_n == 0) bif.req_valid = bif.req_valid & ~bif.req_done;
            else if (seen == total) bif.req_valid = '0;
         end
         if (rnd_drop && bif.m_start && !prev) begin
            g = int'(bif.grant);
            if ($urandom_range(3) == 0) bif.req_valid[PW'(g)] = 1'b0;
            bif.req_addr[g*32 +: 32]  = $urandom;
            bif.req_wdata[g*32 +: 32] = $urandom;
            bif.req_write[PW'(g)]     = ~bif.req_write[PW'(g)];
         end
         prev = bif.m_start;
      end
      check("batch completions", 64'(seen), 64'(total));
      if (seen < total) begin
         bif.req_valid = '0;
         do_reset();
      end
   endtask

   // Bus slave standing in for bus_control.
   initial begin : slave
      bit          in_data;
      bit          rdy;
      logic [32:0] d;
      in_data          = 1'b0;
      bif.m_ready      = 1'b1;
      bif.m_read_data  = '0;
      bif.m_response   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            in_data     = 1'b0;
            bif.m_ready = 1'b1;
         end else begin
            if (rdy_script.size() > 0) rdy = rdy_script.pop_front();
            else rdy = (int'($urandom_range(99)) < ready_pct);
            bif.m_ready = rdy;
            if (in_data && rdy) begin
               if (data_script.size() > 0) d = data_script.pop_front();
               else d = {($urandom_range(9) == 0), $urandom};
               bif.m_read_data = d[31:0];
               bif.m_response  = d[32];
               resp_q.push_back(d);
               in_data = 1'b0;
            end else begin
               bif.m_read_data = $urandom;
               bif.m_response  = 1'($urandom_range(1));
               if (!in_data && bif.m_start && rdy) in_data = 1'b1;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin : monitor
      bit          prev_start;
      bit          have_cur;
      xfer_t       cur;
      xfer_t       e;
      logic [32:0] r;
      prev_start = 1'b0;
      have_cur   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_start = 1'b0;
            have_cur   = 1'b0;
         end else begin
            if (bif.m_start && !prev_start) begin
               if (bus_q.size() == 0) begin
                  check("unexpected m_start, queued", 64'(bus_q.size()), 64'(1));
               end else begin
                  e = bus_q.pop_front();
                  check("start grant", 64'(bif.grant), 64'(e.idx));
                  check("start m_address", 64'(bif.m_address), 64'(e.addr));
                  check("start m_write", 64'(bif.m_write), 64'(e.wr));
                  check("start m_write_data", 64'(bif.m_write_data), 64'(e.wdata));
                  check("start busy", 64'(bif.busy), 64'(1));
                  cur      = e;
                  have_cur = 1'b1;
               end
            end else if (bif.busy && have_cur) begin
               check("hold m_address", 64'(bif.m_address), 64'(cur.addr));
               check("hold m_write_data", 64'(bif.m_write_data), 64'(cur.wdata));
               check("hold grant", 64'(bif.grant), 64'(cur.idx));
            end
            if (!bif.busy) check("idle m_start", 64'(bif.m_start), 64'(0));
            prev_start = bif.m_start;

            if (bif.req_done != '0) begin
               check("done onehot", 64'($onehot(bif.req_done)), 64'(1));
               if (done_q.size() == 0 || resp_q.size() == 0) begin
                  check("unexpected req_done, queued", 64'(done_q.size() * resp_q.size()), 64'(1));
               end else begin
                  e = done_q.pop_front();
                  r = resp_q.pop_front();
                  check("done index", 64'(bif.req_done), 64'({{(N-1){1'b0}}, 1'b1} << e.idx));
                  check("done rdata", 64'(bif.req_rdata), 64'(r[31:0]));
                  check("done resp", 64'(bif.req_resp), 64'(r[32]));
                  check("done busy", 64'(bif.busy), 64'(0));
               end
               have_cur = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int     got;
      logic [N-1:0] sub;
      rst           = 1'b1;
      bif.req_valid = '0;
      bif.req_write = '0;
      bif.req_addr  = '0;
      bif.req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         a_wr[i]    = 1'b0;
         a_addr[i]  = '0;
         a_wdata[i] = '0;
      end

      // Reset values
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst m_start", 64'(bif.m_start), 64'(0));
      check("rst m_write", 64'(bif.m_write), 64'(0));
      check("rst m_address", 64'(bif.m_address), 64'(0));
      check("rst m_write_data", 64'(bif.m_write_data), 64'(0));
      check("rst req_done", 64'(bif.req_done), 64'(0));
      check("rst req_rdata", 64'(bif.req_rdata), 64'(0));
      check("rst req_resp", 64'(bif.req_resp), 64'(0));
      check("rst grant", 64'(bif.grant), 64'(0));
      check("rst busy", 64'(bif.busy), 64'(0));
      rst = 1'b1;

      // Contention: requesters 0 and 1 held continuously for four transfers
      a_addr[0] = 32'h10;
      a_addr[1] = 32'h20;
      run_batch(3'b011, 4, 1'b0);

      // Single read, exact latency with an always-ready bus
      a_wr[0]   = 1'b0;
      a_addr[0] = 32'h0000_0100;
      apply_attrs();
      got = model_expect(3'b001, 0);
      data_script.push_back({1'b0, 32'hDEADBEEF});
      @(negedge clk);
      bif.req_valid[0] = 1'b1;
      @(negedge clk);
      check("lat m_start c1", 64'(bif.m_start), 64'(1));
      check("lat m_address c1", 64'(bif.m_address), 64'(32'h100));
      @(negedge clk);
      check("lat m_start c2", 64'(bif.m_start), 64'(0));
      check("lat busy c2", 64'(bif.busy), 64'(1));
      check("lat req_done c2", 64'(bif.req_done), 64'(0));
      @(negedge clk);
      check("lat req_done c3", 64'(bif.req_done), 64'(3'b001));
      check("lat req_rdata c3", 64'(bif.req_rdata), 64'(32'hDEADBEEF));
      check("lat req_resp c3", 64'(bif.req_resp), 64'(0));
      bif.req_valid[0] = 1'b0;
      @(negedge clk);
      check("lat done cleared", 64'(bif.req_done), 64'(0));

      // Wait states: requester 1 write, 2 low cycles in ISSUE, 3 in DATA
      a_wr[1]    = 1'b1;
      a_addr[1]  = 32'h4000_0000;
      a_wdata[1] = 32'h1234_5678;
      apply_attrs();
      got = model_expect(3'b010, 0);
      @(posedge clk);
      rdy_script = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      @(negedge clk);
      bif.req_valid[1] = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check("ws issue m_start", 64'(bif.m_start), 64'(1));
         check("ws issue m_address", 64'(bif.m_address), 64'(32'h4000_0000));
         check("ws issue m_write", 64'(bif.m_write), 64'(1));
      end
      for (int c = 4; c <= 7; c++) begin
         @(negedge clk);
         check("ws data m_start", 64'(bif.m_start), 64'(0));
         check("ws data busy", 64'(bif.busy), 64'(1));
         check("ws data req_done", 64'(bif.req_done), 64'(0));
         check("ws data m_write_data", 64'(bif.m_write_data), 64'(32'h1234_5678));
      end
      @(negedge clk);
      check("ws req_done", 64'(bif.req_done), 64'(3'b010));
      bif.req_valid[1] = 1'b0;
      @(negedge clk);
      check("ws no duplicate done", 64'(bif.req_done), 64'(0));

      // Error response on requester 2, then 0 and 2 together (pointer advanced)
      a_addr[2] = 32'hE000_0000;
      data_script.push_back({1'b1, 32'hBAD0_0BAD});
      run_batch(3'b100, 0, 1'b0);
      run_batch(3'b101, 0, 1'b0);

      // Reset while in DATA with m_ready low
      a_wr[0]   = 1'b0;
      a_addr[0] = 32'h0000_0200;
      apply_attrs();
      got = model_expect(3'b001, 0);
      @(posedge clk);
      rdy_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      @(negedge clk);
      bif.req_valid[0] = 1'b1;
      @(negedge clk);
      check("rd issue m_start", 64'(bif.m_start), 64'(1));
      @(negedge clk);
      check("rd data busy", 64'(bif.busy), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rd m_start", 64'(bif.m_start), 64'(0));
      check("rd busy", 64'(bif.busy), 64'(0));
      check("rd req_done", 64'(bif.req_done), 64'(0));
      check("rd m_address", 64'(bif.m_address), 64'(0));
      bif.req_valid = '0;
      flush_model();
      repeat (2) @(negedge clk);
      check("rd no done during reset", 64'(bif.req_done), 64'(0));
      rst = 1'b1;
      a_addr[1] = 32'h0000_0300;
      run_batch(3'b010, 0, 1'b0);

      // Requester 0 drops req_valid during ISSUE
      a_addr[0] = 32'h0000_0400;
      apply_attrs();
      got = model_expect(3'b001, 0);
      @(posedge clk);
      rdy_script = '{1'b1, 1'b0, 1'b1};
      @(negedge clk);
      bif.req_valid[0] = 1'b1;
      @(negedge clk);
      check("drop m_start", 64'(bif.m_start), 64'(1));
      bif.req_valid[0] = 1'b0;
      got = 0;
      for (int c = 0; c < 50 && got == 0; c++) begin
         @(negedge clk);
         if (bif.req_done != '0) got = int'(bif.req_done);
      end
      check("drop req_done", 64'(got), 64'(3'b001));
      repeat (4) begin
         @(negedge clk);
         check("drop stays idle", 64'({bif.busy, bif.m_start}), 64'(0));
      end

      // Randomized batches
      for (int b = 0; b < 60; b++) begin
         ready_pct = int'($urandom_range(100, 40));
         for (int i = 0; i < N; i++) begin
            a_wr[i]    = 1'($urandom_range(1));
            a_addr[i]  = $urandom;
            a_wdata[i] = $urandom;
         end
         sub = N'($urandom_range((1 << N) - 1, 1));
         if ($urandom_range(3) == 0) run_batch(sub, int'($urandom_range(6, 2)), 1'b0);
         else run_batch(sub, 0, 1'b1);
      end

      repeat (5) @(negedge clk);
      check("bus_q drained", 64'(bus_q.size()), 64'(0));
      check("done_q drained", 64'(done_q.size()), 64'(0));
      check("resp_q drained", 64'(resp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
